olink_bringup_seq: RTL and testbench

Link bring-up and recovery sequencer for the optical link GTX channel, clocked from the free-running 125 MHz system clock. It steps the transceiver through a fixed sequence: PLL reset, TX reset, RX reset, then alignment qualification. It holds the link in UP while receive quality is good, re-sequences on loss of lock or a sustained bad-data burst, and gives up after a bounded number of retries. Its outputs drive the GTX reset/control pulses now issued by software writes, and its status is exported for the link status registers.

---
 rtl/olink_bringup_seq.sv | 204 ++++++++++++++++++++
 tb/tb_olink_bringup_seq.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/olink_bringup_seq.sv
// Optical link GTX bring-up and recovery sequencer.
// Sequences PLL/TX/RX resets, qualifies alignment, and monitors link health in UP.
module olink_bringup_seq #(
    parameter int unsigned PULSE_CYCLES      = 16,
    parameter int unsigned TIMEOUT_CYCLES    = 1250000,
    parameter int unsigned ALIGN_GOOD_CYCLES = 1024,
    parameter int unsigned BAD_LIMIT         = 64,
    parameter int unsigned MAX_RETRY         = 7
) (
    input  logic        i_clk_125,
    input  logic        i_reset_n,
    input  logic        i_enable,
    input  logic        i_force_restart,
    input  logic        i_cpll_lock,
    input  logic        i_qpll_lock,
    input  logic        i_clk_link_lock,
    input  logic        i_tx_fsm_done,
    input  logic        i_rx_fsm_done,
    input  logic        i_rx_reset_done,
    input  logic        i_link_ok,
    output logic        o_cpll_reset,
    output logic        o_qpll_reset,
    output logic        o_tx_soft_reset,
    output logic        o_rx_soft_reset,
    output logic        o_link_up,
    output logic        o_fail,
    output logic [3:0]  o_state,
    output logic [3:0]  o_retry_count,
    output logic [15:0] o_drop_count
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_PLL_RST  = 4'd1,
        S_PLL_WAIT = 4'd2,
        S_TX_RST   = 4'd3,
        S_TX_WAIT  = 4'd4,
        S_RX_RST   = 4'd5,
        S_RX_WAIT  = 4'd6,
        S_ALIGN    = 4'd7,
        S_UP       = 4'd8,
        S_FAIL     = 4'd9
    } state_t;

    localparam logic [23:0] PULSE_LAST = 24'(PULSE_CYCLES - 1);
    localparam logic [23:0] TMO_LAST   = 24'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] GOOD_LIM   = 16'(ALIGN_GOOD_CYCLES);
    localparam logic [15:0] BAD_LIM    = 16'(BAD_LIMIT);
    localparam logic [3:0]  RETRY_LIM  = 4'(MAX_RETRY);

    state_t      r_state;
    logic [6:0]  r_sync1;
    logic [6:0]  r_sync2;
    logic [23:0] r_timer;
    logic [15:0] r_good;
    logic [15:0] r_bad;
    logic [3:0]  r_retry;
    logic [15:0] r_drop;
    logic        r_cpll_reset;
    logic        r_qpll_reset;
    logic        r_tx_soft_reset;
    logic        r_rx_soft_reset;
    logic        r_link_up;
    logic        r_fail;

    state_t      w_state_nxt;
    logic [3:0]  w_retry_nxt;
    logic [3:0]  w_retry_inc;
    logic [15:0] w_good_nxt;
    logic [15:0] w_bad_nxt;
    logic        w_drop_inc;
    logic        w_restart;
    logic        w_fail_try;
    logic        w_clr;
    logic        w_timeout;
    logic        w_pulse_end;
    logic        w_locks;
    logic        w_tx_done;
    logic        w_rx_done;
    logic        w_link_ok;
    logic [6:0]  w_async;

    assign w_async = {i_link_ok, i_rx_reset_done, i_rx_fsm_done,
                      i_tx_fsm_done, i_clk_link_lock, i_qpll_lock,
                      i_cpll_lock};

    assign w_locks     = &r_sync2[2:0];
    assign w_tx_done   = r_sync2[3];
    assign w_rx_done   = r_sync2[4] & r_sync2[5];
    assign w_link_ok   = r_sync2[6];
    assign w_timeout   = (r_timer == TMO_LAST);
    assign w_pulse_end = (r_timer == PULSE_LAST);
    assign w_retry_inc = r_retry + 4'd1;
    assign w_good_nxt  = w_link_ok ? r_good + 16'd1 : 16'd0;
    assign w_bad_nxt   = w_link_ok ? 16'd0 : r_bad + 16'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_retry_nxt = r_retry;
        w_drop_inc  = 1'b0;
        w_restart   = 1'b0;
        w_fail_try  = 1'b0;
        if (!i_enable) begin
            w_state_nxt = S_IDLE;
            w_retry_nxt = 4'd0;
        end else if (i_force_restart && (r_state != S_IDLE)) begin
            w_state_nxt = S_PLL_RST;
            w_retry_nxt = 4'd0;
            w_restart   = 1'b1;
        end else begin
            unique case (r_state)
                S_IDLE:     w_state_nxt = S_PLL_RST;
                S_PLL_RST:  if (w_pulse_end) w_state_nxt = S_PLL_WAIT;
                S_PLL_WAIT: begin
                    if (w_locks) w_state_nxt = S_TX_RST;
                    else if (w_timeout) w_fail_try = 1'b1;
                end
                S_TX_RST:   if (w_pulse_end) w_state_nxt = S_TX_WAIT;
                S_TX_WAIT: begin
                    if (w_tx_done) w_state_nxt = S_RX_RST;
                    else if (w_timeout) w_fail_try = 1'b1;
                end
                S_RX_RST:   if (w_pulse_end) w_state_nxt = S_RX_WAIT;
                S_RX_WAIT: begin
                    if (w_rx_done) w_state_nxt = S_ALIGN;
                    else if (w_timeout) w_fail_try = 1'b1;
                end
                S_ALIGN: begin
                    if (w_good_nxt == GOOD_LIM) begin
                        w_state_nxt = S_UP;
                        w_retry_nxt = 4'd0;
                    end else if (w_timeout) begin
                        w_fail_try = 1'b1;
                    end
                end
                // Lock loss outranks a bad burst; either counts one drop.
                S_UP: begin
                    if (!w_locks) begin
                        w_drop_inc  = 1'b1;
                        w_state_nxt = S_PLL_RST;
                    end else if (w_bad_nxt == BAD_LIM) begin
                        w_drop_inc  = 1'b1;
                        w_state_nxt = S_RX_RST;
                    end
                end
                S_FAIL:     w_state_nxt = S_FAIL;
                default:    w_state_nxt = S_IDLE;
            endcase
            if (w_fail_try) begin
                w_retry_nxt = w_retry_inc;
                w_state_nxt = (w_retry_inc == RETRY_LIM) ? S_FAIL : S_PLL_RST;
            end
        end
    end

    assign w_clr = (w_state_nxt != r_state) || w_restart;

    always_ff @(posedge i_clk_125) begin
        if (!i_reset_n) begin
            r_state         <= S_IDLE;
            r_sync1         <= '0;
            r_sync2         <= '0;
            r_timer         <= '0;
            r_good          <= '0;
            r_bad           <= '0;
            r_retry         <= '0;
            r_drop          <= '0;
            r_cpll_reset    <= 1'b0;
            r_qpll_reset    <= 1'b0;
            r_tx_soft_reset <= 1'b0;
            r_rx_soft_reset <= 1'b0;
            r_link_up       <= 1'b0;
            r_fail          <= 1'b0;
        end else begin
            r_sync1 <= w_async;
            r_sync2 <= r_sync1;
            r_state <= w_state_nxt;
            r_retry <= w_retry_nxt;
            if (w_drop_inc && (r_drop != 16'hFFFF)) r_drop <= r_drop + 16'd1;
            if (w_clr) r_timer <= '0;
            else if (r_timer != 24'hFFFFFF) r_timer <= r_timer + 24'd1;
            r_good <= (!w_clr && (r_state == S_ALIGN)) ? w_good_nxt : 16'd0;
            r_bad  <= (!w_clr && (r_state == S_UP)) ? w_bad_nxt : 16'd0;
            // Outputs decode the state being entered so they line up with it.
            r_cpll_reset    <= (w_state_nxt == S_PLL_RST);
            r_qpll_reset    <= (w_state_nxt == S_PLL_RST);
            r_tx_soft_reset <= (w_state_nxt == S_TX_RST);
            r_rx_soft_reset <= (w_state_nxt == S_RX_RST);
            r_link_up       <= (w_state_nxt == S_UP);
            r_fail          <= (w_state_nxt == S_FAIL);
        end
    end

    assign o_cpll_reset    = r_cpll_reset;
    assign o_qpll_reset    = r_qpll_reset;
    assign o_tx_soft_reset = r_tx_soft_reset;
    assign o_rx_soft_reset = r_rx_soft_reset;
    assign o_link_up       = r_link_up;
    assign o_fail          = r_fail;
    assign o_state         = r_state;
    assign o_retry_count   = r_retry;
    assign o_drop_count    = r_drop;

endmodule

// File: tb/tb_olink_bringup_seq.sv
// Scenario bench for olink_bringup_seq with randomized timing and arithmetic expectations.
module tb_olink_bringup_seq;

    localparam int PULSE = 4;
    localparam int TMO   = 100;
    localparam int GOOD  = 8;
    localparam int BADL  = 4;
    localparam int MAXR  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0, en = 1'b0, frc = 1'b0;
    logic cl = 1'b0, ql = 1'b0, kl = 1'b0;
    logic txd = 1'b0, rxd = 1'b0, rrd = 1'b0, lok = 1'b0;
    logic cpll, qpll, txr, rxr, up, fl;
    logic [3:0] st, rc;
    logic [15:0] dc;

    int n_pass = 0;
    int n_total = 0;
    int exp_drop = 0;

    olink_bringup_seq #(
        .PULSE_CYCLES(PULSE), .TIMEOUT_CYCLES(TMO),
        .ALIGN_GOOD_CYCLES(GOOD), .BAD_LIMIT(BADL), .MAX_RETRY(MAXR)
    ) dut (
        .i_clk_125(clk), .i_reset_n(rst_n), .i_enable(en),
        .i_force_restart(frc), .i_cpll_lock(cl), .i_qpll_lock(ql),
        .i_clk_link_lock(kl), .i_tx_fsm_done(txd), .i_rx_fsm_done(rxd),
        .i_rx_reset_done(rrd), .i_link_ok(lok),
        .o_cpll_reset(cpll), .o_qpll_reset(qpll),
        .o_tx_soft_reset(txr), .o_rx_soft_reset(rxr),
        .o_link_up(up), .o_fail(fl), .o_state(st),
        .o_retry_count(rc), .o_drop_count(dc)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_status(input logic v);
        cl = v; ql = v; kl = v; txd = v; rxd = v; rrd = v; lok = v;
    endtask

    task automatic do_reset;
        rst_n = 1'b0; en = 1'b0; frc = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        exp_drop = 0;
    endtask

    task automatic go_up(output bit ok);
        int n;
        set_status(1'b1);
        en = 1'b1;
        n = 0;
        while (up !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        ok = (up === 1'b1);
    endtask

    task automatic wait_state(input logic [3:0] s, input int budget, output bit ok);
        int n;
        n = 0;
        while (st !== s && n < budget) begin
            tick();
            n++;
        end
        ok = (st === s);
    endtask

    task automatic test_reset;
        set_status(1'b1);
        en = 1'b1;
        rst_n = 1'b0;
        repeat (2) tick();
        n_total++;
        if (st !== 4'd0) $display("FAIL rst_state: got %0d want 0", st);
        else n_pass++;
        n_total++;
        if ({cpll, qpll, txr, rxr, up, fl} !== 6'b0)
            $display("FAIL rst_outs: got %b want 000000", {cpll, qpll, txr, rxr, up, fl});
        else n_pass++;
        n_total++;
        if (rc !== 4'd0 || dc !== 16'd0) $display("FAIL rst_counts: got %0d/%0d want 0/0", rc, dc);
        else n_pass++;
        en = 1'b0;
        rst_n = 1'b1;
        repeat (5) tick();
        frc = 1'b1;
        tick();
        frc = 1'b0;
        repeat (2) tick();
        n_total++;
        if (st !== 4'd0) $display("FAIL idle_hold: got %0d want 0", st);
        else n_pass++;
    endtask

    task automatic test_bringup;
        int cc, cq, ct, cr, ca, n;
        bit ovl;
        do_reset();
        cc = 0; cq = 0; ct = 0; cr = 0; ca = 0; n = 0; ovl = 0;
        set_status(1'b1);
        en = 1'b1;
        while (up !== 1'b1 && n < 200) begin
            tick();
            n++;
            cc += int'(cpll); cq += int'(qpll);
            ct += int'(txr); cr += int'(rxr);
            ca += int'(st == 4'd7);
            if ((int'(cpll) + int'(txr) + int'(rxr)) > 1 || cpll !== qpll) ovl = 1;
        end
        n_total++;
        if (cc !== PULSE) $display("FAIL bu_cpll_width: got %0d want %0d", cc, PULSE);
        else n_pass++;
        n_total++;
        if (cq !== PULSE) $display("FAIL bu_qpll_width: got %0d want %0d", cq, PULSE);
        else n_pass++;
        n_total++;
        if (ct !== PULSE) $display("FAIL bu_tx_width: got %0d want %0d", ct, PULSE);
        else n_pass++;
        n_total++;
        if (cr !== PULSE) $display("FAIL bu_rx_width: got %0d want %0d", cr, PULSE);
        else n_pass++;
        n_total++;
        if (ca !== GOOD) $display("FAIL bu_align_len: got %0d want %0d", ca, GOOD);
        else n_pass++;
        n_total++;
        if (n !== 3 * PULSE + 3 + GOOD + 1) $display("FAIL bu_latency: got %0d want %0d", n, 3 * PULSE + 3 + GOOD + 1);
        else n_pass++;
        n_total++;
        if (up !== 1'b1 || st !== 4'd8) $display("FAIL bu_up: got up=%b st=%0d want 1/8", up, st);
        else n_pass++;
        n_total++;
        if (rc !== 4'd0 || fl !== 1'b0) $display("FAIL bu_retry: got %0d fail=%b want 0/0", rc, fl);
        else n_pass++;
        n_total++;
        if (ovl !== 1'b0) $display("FAIL bu_exclusive: got %b want 0", ovl);
        else n_pass++;
    endtask

    task automatic test_bad_burst;
        int len, n;
        logic [3:0] es;
        for (int i = 0; i < 6; i++) begin
            len = (i == 0) ? 3 : (i == 1) ? 4 : int'($urandom_range(1, 6));
            lok = 1'b0;
            repeat (len) tick();
            lok = 1'b1;
            repeat (6 - len) tick();
            if (len >= BADL) exp_drop++;
            es = (len >= BADL) ? 4'd5 : 4'd8;
            n_total++;
            if (st !== es) $display("FAIL bb_state len=%0d: got %0d want %0d", len, st, es);
            else n_pass++;
            n_total++;
            if (dc !== 16'(exp_drop)) $display("FAIL bb_drop len=%0d: got %0d want %0d", len, dc, exp_drop);
            else n_pass++;
            if (len >= BADL) begin
                n = 0;
                while (up !== 1'b1 && n < 100) begin
                    tick();
                    n++;
                end
                n_total++;
                if (up !== 1'b1) $display("FAIL bb_reup: got %b want 1", up);
                else n_pass++;
            end
        end
    endtask

    task automatic test_lock_and_bad;
        lok = 1'b0;
        repeat (3) tick();
        ql = 1'b0;
        tick();
        ql = 1'b1;
        lok = 1'b1;
        repeat (2) tick();
        exp_drop++;
        n_total++;
        if (st !== 4'd1) $display("FAIL lb_state: got %0d want 1", st);
        else n_pass++;
        n_total++;
        if (dc !== 16'(exp_drop)) $display("FAIL lb_drop: got %0d want %0d", dc, exp_drop);
        else n_pass++;
        repeat (10) tick();
        n_total++;
        if (dc !== 16'(exp_drop)) $display("FAIL lb_drop_once: got %0d want %0d", dc, exp_drop);
        else n_pass++;
    endtask

    task automatic test_retry_fail;
        bit ok;
        int cnt;
        logic [3:0] es;
        do_reset();
        set_status(1'b1);
        cl = 1'b0; ql = 1'b0; kl = 1'b0;
        en = 1'b1;
        for (int k = 1; k <= MAXR; k++) begin
            wait_state(4'd2, 50, ok);
            n_total++;
            if (!ok) $display("FAIL rf_reach_wait: got st=%0d want 2", st);
            else n_pass++;
            cnt = 0;
            while (st === 4'd2 && cnt < 300) begin
                tick();
                cnt++;
            end
            n_total++;
            if (cnt !== TMO) $display("FAIL rf_timeout_len: got %0d want %0d", cnt, TMO);
            else n_pass++;
            n_total++;
            if (rc !== 4'(k)) $display("FAIL rf_retry: got %0d want %0d", rc, k);
            else n_pass++;
            es = (k < MAXR) ? 4'd1 : 4'd9;
            n_total++;
            if (st !== es || fl !== (k == MAXR)) $display("FAIL rf_state: got %0d fail=%b want %0d", st, fl, es);
            else n_pass++;
        end
        repeat (5) tick();
        n_total++;
        if (st !== 4'd9) $display("FAIL rf_hold: got %0d want 9", st);
        else n_pass++;
        frc = 1'b1;
        tick();
        frc = 1'b0;
        n_total++;
        if (st !== 4'd1 || rc !== 4'd0 || fl !== 1'b0)
            $display("FAIL rf_force: got st=%0d rc=%0d fail=%b want 1/0/0", st, rc, fl);
        else n_pass++;
    endtask

    task automatic test_align_timeout;
        bit ok, seen;
        int cnt, per;
        do_reset();
        set_status(1'b1);
        lok = 1'b0;
        en = 1'b1;
        wait_state(4'd7, 100, ok);
        n_total++;
        if (!ok) $display("FAIL at_reach_align: got st=%0d want 7", st);
        else n_pass++;
        per = int'($urandom_range(2, GOOD - 1));
        cnt = 0;
        seen = 0;
        while (st === 4'd7 && cnt < 300) begin
            if (cnt % per == 0) lok = ~lok;
            tick();
            cnt++;
            if (up === 1'b1) seen = 1;
        end
        n_total++;
        if (cnt !== TMO) $display("FAIL at_len per=%0d: got %0d want %0d", per, cnt, TMO);
        else n_pass++;
        n_total++;
        if (seen !== 1'b0) $display("FAIL at_no_up: got %b want 0", seen);
        else n_pass++;
        n_total++;
        if (rc !== 4'd1 || st !== 4'd1) $display("FAIL at_retry: got rc=%0d st=%0d want 1/1", rc, st);
        else n_pass++;
    endtask

    task automatic test_lock_latency;
        bit ok;
        int d, idx;
        do_reset();
        set_status(1'b1);
        cl = 1'b0; ql = 1'b0; kl = 1'b0;
        en = 1'b1;
        wait_state(4'd2, 50, ok);
        n_total++;
        if (!ok) $display("FAIL ll_reach_wait: got st=%0d want 2", st);
        else n_pass++;
        idx = int'($urandom_range(0, 2));
        d = int'($urandom_range(0, 30));
        cl = (idx != 0); ql = (idx != 1); kl = (idx != 2);
        repeat (d) tick();
        cl = 1'b1; ql = 1'b1; kl = 1'b1;
        repeat (2) tick();
        n_total++;
        if (st !== 4'd2) $display("FAIL ll_early d=%0d: got %0d want 2", d, st);
        else n_pass++;
        tick();
        n_total++;
        if (st !== 4'd3 || txr !== 1'b1) $display("FAIL ll_decide d=%0d: got st=%0d tx=%b want 3/1", d, st, txr);
        else n_pass++;
    endtask

    task automatic test_enable_off;
        bit ok;
        int k;
        do_reset();
        set_status(1'b1);
        en = 1'b1;
        wait_state(4'd3, 50, ok);
        k = int'($urandom_range(0, PULSE - 1));
        repeat (k) tick();
        n_total++;
        if (!ok || st !== 4'd3 || txr !== 1'b1) $display("FAIL eo_in_tx k=%0d: got st=%0d tx=%b want 3/1", k, st, txr);
        else n_pass++;
        en = 1'b0;
        tick();
        n_total++;
        if (st !== 4'd0 || txr !== 1'b0 || rc !== 4'd0)
            $display("FAIL eo_idle: got st=%0d tx=%b rc=%0d want 0/0/0", st, txr, rc);
        else n_pass++;
    endtask

    task automatic test_reset_in_up;
        bit ok;
        int n;
        do_reset();
        go_up(ok);
        n_total++;
        if (!ok) $display("FAIL ru_reach_up: got up=%b want 1", up);
        else n_pass++;
        lok = 1'b0;
        repeat (BADL) tick();
        lok = 1'b1;
        repeat (6 - BADL) tick();
        exp_drop++;
        n_total++;
        if (dc !== 16'(exp_drop)) $display("FAIL ru_drop: got %0d want %0d", dc, exp_drop);
        else n_pass++;
        n = 0;
        while (up !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        rst_n = 1'b0;
        tick();
        n_total++;
        if ({cpll, qpll, txr, rxr, up, fl} !== 6'b0 || st !== 4'd0)
            $display("FAIL ru_outs: got %b st=%0d want 000000/0", {cpll, qpll, txr, rxr, up, fl}, st);
        else n_pass++;
        n_total++;
        if (dc !== 16'd0 || rc !== 4'd0) $display("FAIL ru_counts: got %0d/%0d want 0/0", dc, rc);
        else n_pass++;
        rst_n = 1'b1;
        en = 1'b0;
        tick();
    endtask

    initial begin
        bit ok;
        test_reset();
        test_bringup();
        test_bad_burst();
        test_lock_and_bad();
        test_retry_fail();
        test_align_timeout();
        test_lock_latency();
        test_enable_off();
        test_reset_in_up();
        do_reset();
        go_up(ok);
        n_total++;
        if (!ok) $display("FAIL final_up: got up=%b want 1", up);
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
